// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle CPU controller.
package cpu_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned REG_W   = 3;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned SH_W    = 2;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned VSEL_W  = 2;

    typedef enum logic [2:0] {
        WAIT, DECODE, WIMM, GET_A, GET_B, ALU, WREG, HALT
    } state_t;

    localparam logic [OPC_W-1:0] OPC_MOV  = 3'b110;
    localparam logic [OPC_W-1:0] OPC_ALU  = 3'b101;
    localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_NOT = 2'b11;

    localparam logic [OP_W-1:0] MOV_IMM = 2'b10;
    localparam logic [OP_W-1:0] MOV_REG = 2'b00;

    localparam logic [VSEL_W-1:0] VSEL_C   = 2'b00;
    localparam logic [VSEL_W-1:0] VSEL_IMM = 2'b01;

    typedef struct packed {
        logic               w;
        logic [REG_W-1:0]   readnum;
        logic [REG_W-1:0]   writenum;
        logic               write;
        logic [VSEL_W-1:0]  vsel;
        logic               loada;
        logic               loadb;
        logic               loadc;
        logic               loads;
        logic               asel;
        logic               bsel;
        logic [ALUOP_W-1:0] aluop;
        logic [SH_W-1:0]    shift;
    } ctrl_t;

    // Control word presented while the FSM sits in state st.
    function automatic ctrl_t ctrl_for(input state_t           st,
                                       input logic [OPC_W-1:0] opcode,
                                       input logic [OP_W-1:0]  op,
                                       input logic [REG_W-1:0] rn,
                                       input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rm,
                                       input logic [SH_W-1:0]  sh);
        ctrl_t c;
        logic  mov_reg;
        c       = '0;
        mov_reg = (opcode == OPC_MOV);
        case (st)
            WAIT: c.w = 1'b1;
            WIMM: begin
                c.writenum = rn;
                c.vsel     = VSEL_IMM;
                c.write    = 1'b1;
            end
            GET_A: begin
                c.readnum = rn;
                c.loada   = 1'b1;
            end
            GET_B: begin
                c.readnum = rm;
                c.loadb   = 1'b1;
                c.shift   = sh;
            end
            ALU: begin
                c.shift = sh;
                c.asel  = mov_reg || (op == ALU_NOT);
                c.aluop = mov_reg ? ALU_ADD : op;
                c.loads = 1'b1;
                c.loadc = !((opcode == OPC_ALU) && (op == ALU_SUB));
            end
            WREG: begin
                c.writenum = rd;
                c.vsel     = VSEL_C;
                c.write    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_decoder.sv
// Splits the held instruction into its fields and sign-extends imm8.
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0]  ir,
    output logic [OPC_W-1:0]   opcode,
    output logic [OP_W-1:0]    op,
    output logic [REG_W-1:0]   rn,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rm,
    output logic [SH_W-1:0]    sh,
    output logic [DATA_W-1:0]  sximm8
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM with instruction register; opcode 111 halts the
// controller when CPU_HALT_EN is defined, otherwise it is treated as illegal.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                s,
    input  logic [DATA_W-1:0]   instr,
    output logic                w,
    output logic [REG_W-1:0]    readnum,
    output logic [REG_W-1:0]    writenum,
    output logic                write,
    output logic [VSEL_W-1:0]   vsel,
    output logic                loada,
    output logic                loadb,
    output logic                loadc,
    output logic                loads,
    output logic                asel,
    output logic                bsel,
    output logic [ALUOP_W-1:0]  ALUop,
    output logic [SH_W-1:0]     shift,
    output logic [DATA_W-1:0]   sximm8
);

    state_t              state, nxt;
    logic [DATA_W-1:0]   ir;
    ctrl_t               ctrl_q;
    logic [OPC_W-1:0]    opcode;
    logic [OP_W-1:0]     op;
    logic [REG_W-1:0]    rn, rd, rm;
    logic [SH_W-1:0]     sh;

    cpu_decoder u_dec (
        .ir     (ir),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .sximm8 (sximm8)
    );

    // Next-state decode.
    always_comb begin
        nxt = state;
        case (state)
            WAIT:   if (s) nxt = DECODE;
            DECODE: begin
                if ((opcode == OPC_MOV) && (op == MOV_IMM))      nxt = WIMM;
                else if ((opcode == OPC_MOV) && (op == MOV_REG)) nxt = GET_B;
                else if ((opcode == OPC_ALU) && (op == ALU_NOT)) nxt = GET_B;
                else if (opcode == OPC_ALU)                      nxt = GET_A;
`ifdef CPU_HALT_EN
                else if (opcode == OPC_HALT)                     nxt = HALT;
`endif
                else                                             nxt = WAIT;
            end
            WIMM:   nxt = WAIT;
            GET_A:  nxt = GET_B;
            GET_B:  nxt = ALU;
            ALU:    nxt = ((opcode == OPC_ALU) && (op == ALU_SUB)) ? WAIT : WREG;
            WREG:   nxt = WAIT;
            HALT:   nxt = HALT;
            default: nxt = WAIT;
        endcase
    end

    // Outputs are registered alongside the state so they line up with it
    // exactly; IR is stable from DECODE onward, so decoding against it is safe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= WAIT;
            ir       <= '0;
            ctrl_q   <= '0;
            ctrl_q.w <= 1'b1;
        end else begin
            state  <= nxt;
            ctrl_q <= ctrl_for(nxt, opcode, op, rn, rd, rm, sh);
            if ((state == WAIT) && s)
                ir <= instr;
        end
    end

    assign w        = ctrl_q.w;
    assign readnum  = ctrl_q.readnum;
    assign writenum = ctrl_q.writenum;
    assign write    = ctrl_q.write;
    assign vsel     = ctrl_q.vsel;
    assign loada    = ctrl_q.loada;
    assign loadb    = ctrl_q.loadb;
    assign loadc    = ctrl_q.loadc;
    assign loads    = ctrl_q.loads;
    assign asel     = ctrl_q.asel;
    assign bsel     = ctrl_q.bsel;
    assign ALUop    = ctrl_q.aluop;
    assign shift    = ctrl_q.shift;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed, table-driven bench for cpu_controller (optionally built with CPU_HALT_EN).
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic        s;
    logic [15:0] instr;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, ALUop, shift;
    logic [15:0] sximm8;

    int tests;
    int failed;

    cpu_controller dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .instr    (instr),
        .w        (w),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .bsel     (bsel),
        .ALUop    (ALUop),
        .shift    (shift),
        .sximm8   (sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads, asel, bsel, ALUop, shift}
    logic [19:0] act;
    assign act = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                  asel, bsel, ALUop, shift};

    typedef struct {
        logic        s;
        logic [15:0] instr;
        logic [19:0] exp;
        logic        chk_sx;
        logic [15:0] sx;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [19:0] ex(input logic w_e, input logic [2:0] rn_e,
                                      input logic [2:0] wn_e, input logic wr_e,
                                      input logic [1:0] vs_e, input logic la_e,
                                      input logic lb_e, input logic lc_e,
                                      input logic ls_e, input logic as_e,
                                      input logic [1:0] op_e, input logic [1:0] sh_e);
        return {w_e, rn_e, wn_e, wr_e, vs_e, la_e, lb_e, lc_e, ls_e, as_e, 1'b0, op_e, sh_e};
    endfunction

    function automatic vec_t mk(input logic si, input logic [15:0] ins,
                                input logic [19:0] e, input logic c = 1'b0,
                                input logic [15:0] sxv = 16'h0000);
        vec_t v;
        v.s = si; v.instr = ins; v.exp = e; v.chk_sx = c; v.sx = sxv;
        return v;
    endfunction

    task automatic check(input string name, input logic [19:0] e,
                         input logic chk_sx, input logic [15:0] sx);
        tests++;
        if (act !== e) begin
            failed++;
            $display("FAIL %s: ctrl got %05h expected %05h", name, act, e);
        end
        if (chk_sx) begin
            tests++;
            if (sximm8 !== sx) begin
                failed++;
                $display("FAIL %s_sximm8: got %04h expected %04h", name, sximm8, sx);
            end
        end
    endtask

    task automatic step(input logic si, input logic [15:0] ins, input string name,
                        input logic [19:0] e, input logic c = 1'b0,
                        input logic [15:0] sxv = 16'h0000);
        @(negedge clk);
        s = si;
        instr = ins;
        @(posedge clk);
        #1;
        check(name, e, c, sxv);
    endtask

    logic [19:0] Z, W;

    initial begin
        tests  = 0;
        failed = 0;
        Z = ex(0,0,0,0,0,0,0,0,0,0,0,0);
        W = ex(1,0,0,0,0,0,0,0,0,0,0,0);

        // MOV R0,#7
        tbl.push_back(mk(1, 16'hD007, Z));
        tbl.push_back(mk(0, 16'hD007, ex(0,0,0,1,1,0,0,0,0,0,0,0), 1, 16'h0007));
        tbl.push_back(mk(0, 16'hD007, W));
        // ADD R2,R1,R0,LSL#1
        tbl.push_back(mk(1, 16'hA148, Z));
        tbl.push_back(mk(0, 16'hA148, ex(0,1,0,0,0,1,0,0,0,0,0,0)));
        tbl.push_back(mk(0, 16'hA148, ex(0,0,0,0,0,0,1,0,0,0,0,1)));
        tbl.push_back(mk(0, 16'hA148, ex(0,0,0,0,0,0,0,1,1,0,0,1)));
        tbl.push_back(mk(0, 16'hA148, ex(0,0,2,1,0,0,0,0,0,0,0,0)));
        tbl.push_back(mk(0, 16'hA148, W));
        // CMP R1,R0
        tbl.push_back(mk(1, 16'hA900, Z));
        tbl.push_back(mk(0, 16'hA900, ex(0,1,0,0,0,1,0,0,0,0,0,0)));
        tbl.push_back(mk(0, 16'hA900, ex(0,0,0,0,0,0,1,0,0,0,0,0)));
        tbl.push_back(mk(0, 16'hA900, ex(0,0,0,0,0,0,0,0,1,0,1,0)));
        tbl.push_back(mk(0, 16'hA900, W));
        // MVN R3,R4
        tbl.push_back(mk(1, 16'hB864, Z));
        tbl.push_back(mk(0, 16'hB864, ex(0,4,0,0,0,0,1,0,0,0,0,0)));
        tbl.push_back(mk(0, 16'hB864, ex(0,0,0,0,0,0,0,1,1,1,3,0)));
        tbl.push_back(mk(0, 16'hB864, ex(0,0,3,1,0,0,0,0,0,0,0,0)));
        tbl.push_back(mk(0, 16'hB864, W));
        // MOV R5,R2,LSR#1
        tbl.push_back(mk(1, 16'hC0B2, Z));
        tbl.push_back(mk(0, 16'hC0B2, ex(0,2,0,0,0,0,1,0,0,0,0,2)));
        tbl.push_back(mk(0, 16'hC0B2, ex(0,0,0,0,0,0,0,1,1,1,0,2)));
        tbl.push_back(mk(0, 16'hC0B2, ex(0,0,5,1,0,0,0,0,0,0,0,0)));
        tbl.push_back(mk(0, 16'hC0B2, W));
        // illegal opcode 000 and MOV with op 01
        tbl.push_back(mk(1, 16'h0000, Z));
        tbl.push_back(mk(0, 16'h0000, W));
        tbl.push_back(mk(1, 16'hC900, Z));
        tbl.push_back(mk(0, 16'hC900, W));
        // s held high, instr switched mid-ADD, then MOV R1,#-1 back-to-back
        tbl.push_back(mk(1, 16'hA148, Z));
        tbl.push_back(mk(1, 16'hD1FF, ex(0,1,0,0,0,1,0,0,0,0,0,0)));
        tbl.push_back(mk(1, 16'hD1FF, ex(0,0,0,0,0,0,1,0,0,0,0,1)));
        tbl.push_back(mk(1, 16'hD1FF, ex(0,0,0,0,0,0,0,1,1,0,0,1)));
        tbl.push_back(mk(1, 16'hD1FF, ex(0,0,2,1,0,0,0,0,0,0,0,0)));
        tbl.push_back(mk(1, 16'hD1FF, W));
        tbl.push_back(mk(1, 16'hD1FF, Z));
        tbl.push_back(mk(0, 16'hD1FF, ex(0,0,1,1,1,0,0,0,0,0,0,0), 1, 16'hFFFF));
        tbl.push_back(mk(0, 16'hD1FF, W));

        // Reset takes effect before any clock edge.
        reset = 1'b1;
        s     = 1'b0;
        instr = 16'h0000;
        #2;
        check("reset_async", W, 1'b1, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i])
            step(tbl[i].s, tbl[i].instr, $sformatf("row%0d", i), tbl[i].exp,
                 tbl[i].chk_sx, tbl[i].sx);

        // Reset between edges while in GET_B, then a fresh instruction.
        step(1, 16'hA148, "rst_dec", Z);
        step(0, 16'hA148, "rst_geta", ex(0,1,0,0,0,1,0,0,0,0,0,0));
        step(0, 16'hA148, "rst_getb", ex(0,0,0,0,0,0,1,0,0,0,0,1));
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid", W, 1'b1, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        step(1, 16'hD007, "rst_fresh_dec", Z);
        step(0, 16'hD007, "rst_fresh_wimm", ex(0,0,0,1,1,0,0,0,0,0,0,0), 1, 16'h0007);
        step(0, 16'hD007, "rst_fresh_wait", W);

        // Opcode 111.
        step(1, 16'hE000, "op7_dec", Z);
`ifdef CPU_HALT_EN
        step(1, 16'hD007, "halt_0", Z);
        for (int k = 1; k <= 3; k++)
            step(1, 16'hD007, $sformatf("halt_%0d", k), Z);
`else
        step(0, 16'hE000, "op7_wait", W);
        step(0, 16'hE000, "op7_idle", W);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
